// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths, reset constants and fetch FSM encoding
package fetch_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] PC_BASE = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch controller: imem handshake, PC advance and IF/ID register
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_STEP = 4,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] npc,
    output logic                  stallF,
    input  logic                  stallD,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_target,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] instrD,
    output logic [WORD_WIDTH-1:0] pcD,
    output logic                  instrD_valid
);

    fetch_state_t          state, next_state;
    logic [WORD_WIDTH-1:0] pending;
    logic [WORD_WIDTH-1:0] hold_buf;
    logic [WORD_WIDTH-1:0] load_word;
    logic                  advance;
    logic                  bubble;
    logic                  load;
    logic                  pending_we;
    logic                  hold_we;

    assign imem_addr = pc;
    assign imem_req  = rst && (state == FETCH_REQ) && !redirect_valid;
    assign stallF    = !rst || !advance;

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        npc        = pc + WORD_WIDTH'(PC_STEP);
        bubble     = 1'b0;
        load       = 1'b0;
        load_word  = imem_rdata;
        pending_we = 1'b0;
        hold_we    = 1'b0;
        case (state)
            FETCH_REQ: begin
                if (redirect_valid) begin
                    advance = 1'b1;
                    npc     = redirect_target;
                    bubble  = 1'b1;
                end else if (imem_gnt) begin
                    next_state = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redirect_valid && imem_rvalid) begin
                    advance    = 1'b1;
                    npc        = redirect_target;
                    bubble     = 1'b1;
                    next_state = FETCH_REQ;
                end else if (redirect_valid) begin
                    // The granted request must still return; park the target until it does.
                    pending_we = 1'b1;
                    next_state = FETCH_DROP;
                end else if (imem_rvalid && !stallD) begin
                    advance    = 1'b1;
                    load       = 1'b1;
                    next_state = FETCH_REQ;
                end else if (imem_rvalid) begin
                    hold_we    = 1'b1;
                    next_state = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                load_word = hold_buf;
                if (redirect_valid) begin
                    advance    = 1'b1;
                    npc        = redirect_target;
                    bubble     = 1'b1;
                    next_state = FETCH_REQ;
                end else if (!stallD) begin
                    advance    = 1'b1;
                    load       = 1'b1;
                    next_state = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                pending_we = redirect_valid;
                if (imem_rvalid) begin
                    advance    = 1'b1;
                    npc        = redirect_valid ? redirect_target : pending;
                    bubble     = 1'b1;
                    next_state = FETCH_REQ;
                end
            end
            default: next_state = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH_REQ;
            pending      <= '0;
            hold_buf     <= '0;
            instrD       <= NOP_INSTR;
            pcD          <= '0;
            instrD_valid <= 1'b0;
        end else begin
            state <= next_state;
            if (pending_we) pending  <= redirect_target;
            if (hold_we)    hold_buf <= imem_rdata;
            // A flush wins over a decode stall; otherwise IF/ID only moves on a completed fetch.
            if (bubble) begin
                instrD       <= NOP_INSTR;
                instrD_valid <= 1'b0;
            end else if (load) begin
                instrD       <= load_word;
                pcD          <= pc;
                instrD_valid <= 1'b1;
            end
        end
    end

endmodule
